piso_feeder: RTL and testbench

PISO_FEEDER -- requirements
Module: piso_feeder

---
 rtl/fsm_defs.sv | 15 +
 rtl/bit_counter.sv | 40 ++++
 rtl/piso_feeder.sv | 106 ++++++++++
 tb/tb_piso_feeder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fsm_defs.sv
// Shared definitions for the serial feeder and the detector FSMs it drives.
// Holds the common state encoding and the found/not-found output levels.
package fsm_defs;

  // Any encoding outside these three recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  localparam logic Found    = 1'b1;
  localparam logic NotFound = 1'b0;

endpackage

// File: rtl/bit_counter.sv
// Bit position counter for the serializer.
// Ports:
//   clk   - system clock, all updates on posedge
//   reset - synchronous active-low reset, clears the count
//   clr   - synchronous clear (wins over en)
//   en    - increment enable
//   cnt   - current count, $clog2(WIDTH) bits wide
module bit_counter #(
  parameter int unsigned WIDTH = 8,
  localparam int unsigned CntW = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            en,
  output logic [CntW-1:0] cnt
);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/piso_feeder.sv
// Parallel-in serial-out feeder for the 1101 detector.
// Captures a WIDTH-bit word when idle and shifts it out one bit per enabled
// cycle, then pulses done for one cycle before becoming ready again.
// Ports:
//   clk       - system clock, all updates on posedge
//   reset     - synchronous active-low reset
//   data_in   - parallel word to serialize
//   load      - capture request, honoured only while ready
//   en        - shift-advance enable; low stalls the stream
//   ready     - high when a load will be accepted
//   x         - serial bit
//   bit_valid - high while x carries a payload bit
//   done      - one-cycle pulse after the last bit of a word
module piso_feeder
  import fsm_defs::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load,
  input  logic             en,
  output logic             ready,
  output logic             x,
  output logic             bit_valid,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  cnt;
  logic             cnt_clr, cnt_en, last_bit;

  bit_counter #(
    .WIDTH(WIDTH)
  ) u_bit_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .cnt  (cnt)
  );

  assign last_bit = (cnt == CntW'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          shreg_d = data_in;
          cnt_clr = 1'b1;
          state_d = StShift;
        end
      end
      StShift: begin
        if (en) begin
          shreg_d = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
          // The counter stops at WIDTH-1 so it never wraps inside a word.
          if (last_bit) begin
            state_d = StDone;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
    end
  end

  // Moore outputs: decoded from state and shift register only.
  always_comb begin
    ready     = 1'b0;
    x         = 1'b0;
    bit_valid = 1'b0;
    done      = NotFound;
    unique case (state_q)
      StIdle:  ready = 1'b1;
      StShift: begin
        bit_valid = 1'b1;
        x         = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
      end
      StDone:  done = Found;
      default: ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_piso_feeder.sv
// Bench for piso_feeder: an MSB-first and an LSB-first instance share stimulus.
module tb_piso_feeder;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         reset, load, en;
  logic [W-1:0] data_in;
  logic         ready_m, x_m, bv_m, done_m;
  logic         ready_l, x_l, bv_l, done_l;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_feeder #(
    .WIDTH    (W),
    .MSB_FIRST(1'b1)
  ) u_msb (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .en       (en),
    .ready    (ready_m),
    .x        (x_m),
    .bit_valid(bv_m),
    .done     (done_m)
  );

  piso_feeder #(
    .WIDTH    (W),
    .MSB_FIRST(1'b0)
  ) u_lsb (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .load     (load),
    .en       (en),
    .ready    (ready_l),
    .x        (x_l),
    .bit_valid(bv_l),
    .done     (done_l)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ready, x, bit_valid, done} of both instances
  task automatic chk_idle(input string tag);
    chk({tag, ".idle"}, {ready_m, x_m, bv_m, done_m, ready_l, x_l, bv_l, done_l}, 8'b1000_1000);
  endtask

  task automatic chk_done(input string tag);
    chk({tag, ".done"}, {ready_m, x_m, bv_m, done_m, ready_l, x_l, bv_l, done_l}, 8'b0001_0001);
  endtask

  // Sends one word starting from an idle cycle. Expected bit at stream position
  // idx is w[W-1-idx] for MSB-first and w[idx] for LSB-first; idx advances on
  // every cycle with en=1. hits counts 1101 windows seen by a chained detector.
  task automatic send_word(input string tag, input logic [W-1:0] w, input bit rand_en,
                           input int stall_at, input int stall_n, input bit poke,
                           output int cycles, output int hits);
    logic [W-1:0] got_m, got_l;
    logic [3:0]   hist;
    int           idx, stalls;
    bit           en_now;
    chk_idle({tag, ".pre"});
    data_in = w;
    load    = 1'b1;
    en      = 1'($urandom_range(0, 1));
    step();
    load    = 1'b0;
    data_in = W'($urandom);
    idx = 0; cycles = 0; hits = 0; stalls = stall_n;
    got_m = '0; got_l = '0; hist = '0;
    for (int c = 0; c < 200 && idx < W; c++) begin
      chk({tag, ".shift"}, {ready_m, bv_m, done_m, x_m, ready_l, bv_l, done_l, x_l},
          {3'b010, w[W-1-idx], 3'b010, w[idx]});
      cycles++;
      if (idx == stall_at && stalls > 0) begin
        en_now = 1'b0;
        stalls--;
      end else if (rand_en) begin
        en_now = ($urandom_range(0, 3) != 0);
      end else begin
        en_now = 1'b1;
      end
      en = en_now;
      if (poke) begin
        load    = ($urandom_range(0, 2) == 0);
        data_in = 8'hFF;
      end
      if (en_now) begin
        got_m      = {got_m[W-2:0], x_m};
        got_l[idx] = x_l;
        hist       = {hist[2:0], x_m};
        if (hist == 4'b1101) hits++;
        idx++;
      end
      step();
    end
    chk({tag, ".len"}, idx, W);
    // A load during the done cycle must be ignored.
    load    = 1'b1;
    data_in = 8'hFF;
    en      = 1'($urandom_range(0, 1));
    chk_done(tag);
    chk({tag, ".word_msb"}, got_m, w);
    chk({tag, ".word_lsb"}, got_l, w);
    step();
    load = 1'b0;
    chk_idle({tag, ".post"});
  endtask

  initial begin
    logic [W-1:0] a5;
    logic [W-1:0] rw;
    int cyc, hits;
    a5 = 8'hA5;

    // Reset wins over load and en.
    reset = 1'b0; load = 1'b1; en = 1'b1; data_in = 8'hFF;
    step();
    step();
    chk_idle("reset");
    reset = 1'b1; load = 1'b0; en = 1'b0;
    step();
    chk_idle("idle_hold");

    send_word("d0", 8'hD0, 1'b0, -1, 0, 1'b0, cyc, hits);
    chk("d0.cycles", cyc, 8);
    chk("d0.detect", hits, 1);

    send_word("0b", 8'h0B, 1'b0, -1, 0, 1'b0, cyc, hits);
    chk("0b.cycles", cyc, 8);

    send_word("stall", 8'hB6, 1'b0, 1, 3, 1'b0, cyc, hits);
    chk("stall.cycles", cyc, 11);

    send_word("poke", 8'hA5, 1'b0, -1, 0, 1'b1, cyc, hits);
    chk("poke.cycles", cyc, 8);

    // Reset during bit 4 aborts the word without a done pulse.
    data_in = a5; load = 1'b1; en = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rst_mid.shift", {bv_m, x_m}, {1'b1, a5[7-i]});
      if (i < 3) step();
    end
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk_idle("rst_mid.after");
    for (int i = 0; i < 4; i++) begin
      step();
      chk_idle("rst_mid.quiet");
    end
    send_word("3c", 8'h3C, 1'b0, -1, 0, 1'b0, cyc, hits);
    chk("3c.cycles", cyc, 8);

    // Back-to-back words, each loaded in the first ready cycle.
    send_word("b2b_d0", 8'hD0, 1'b0, -1, 0, 1'b0, cyc, hits);
    chk("b2b_d0.detect", hits, 1);
    send_word("b2b_0d", 8'h0D, 1'b0, -1, 0, 1'b0, cyc, hits);
    chk("b2b_0d.detect", hits, 1);

    for (int k = 0; k < 12; k++) begin
      rw = W'($urandom);
      send_word("rand", rw, 1'b1, int'($urandom_range(0, W - 1)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), cyc, hits);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
